// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared constants, state encoding and the rotating-priority rank helper used
// by the priority resolver and its rotating priority encoder.
// No ports (package).
// -----------------------------------------------------------------------------
package pic_pkg;

  localparam int NUM_LEVELS  = 8;
  localparam int LEVEL_WIDTH = 3;

  // Level reported when an acknowledge arrives with nothing eligible.
  localparam logic [LEVEL_WIDTH-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } pic_state_e;

  // Rank 0 is the highest priority; the level just above the lowest-priority
  // level gets rank 0. Modulo-8 wrap comes for free from the 3-bit arithmetic.
  function automatic logic [LEVEL_WIDTH-1:0] level_rank(
    input logic [LEVEL_WIDTH-1:0] level,
    input logic [LEVEL_WIDTH-1:0] lowest_level
  );
    return level - lowest_level - 3'd1;
  endfunction

endpackage

// File: rtl/priority_encoder_rotating.sv
// -----------------------------------------------------------------------------
// priority_encoder_rotating
// Combinational priority encoder with a rotating base. The highest priority
// bit is lowest_priority_level+1 (mod 8), descending around the ring.
// Ports:
//   vector_in              in   8  candidate bits
//   lowest_priority_level  in   3  rotation base (lowest priority level)
//   found                  out  1  at least one bit of vector_in is set
//   index                  out  3  highest-priority set bit (0 when !found)
// -----------------------------------------------------------------------------
module priority_encoder_rotating
  import pic_pkg::*;
(
  input  logic [NUM_LEVELS-1:0]  vector_in,
  input  logic [LEVEL_WIDTH-1:0] lowest_priority_level,
  output logic                   found,
  output logic [LEVEL_WIDTH-1:0] index
);

  logic [LEVEL_WIDTH-1:0] level_at_rank [NUM_LEVELS];

  always_comb begin
    for (int k = 0; k < NUM_LEVELS; k++) begin
      level_at_rank[k] = lowest_priority_level + 3'd1 + LEVEL_WIDTH'(k);
    end
  end

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_LEVELS - 1; k >= 0; k--) begin
      if (vector_in[level_at_rank[k]]) begin
        found = 1'b1;
        index = level_at_rank[k];
      end
    end
  end

endmodule

// File: rtl/priority_resolver_in_service.sv
// -----------------------------------------------------------------------------
// priority_resolver_in_service
// Masks latched requests, resolves the highest-priority eligible request
// against the in-service register, raises INT, runs the two-pulse INTA
// sequence, and owns the ISR with EOI / auto-EOI clearing.
//
// Build option: SPECIAL_MASK_MODE_EN
//   defined   - masked ISR bits stop inhibiting while special_mask_mode=1
//   undefined - special_mask_mode is ignored; every ISR bit inhibits
//
// Ports:
//   clock                       in   1  system clock
//   reset_n                     in   1  synchronous active-low reset
//   interrupt_request_register  in   8  latched requests
//   interrupt_mask              in   8  1 = level masked
//   special_mask_mode           in   1  special mask mode
//   lowest_priority_level       in   3  rotation base
//   end_of_interrupt            in   8  one-cycle ISR clear strobe
//   auto_eoi_config             in   1  auto end-of-interrupt
//   interrupt_acknowledge       in   1  one-cycle strobe per INTA pulse
//   interrupt_out               out  1  INT to the CPU (registered)
//   freeze                      out  1  holds the request latch during INTA
//   clear_interrupt_request     out  8  one-hot clear pulse to the latch
//   in_service_register         out  8  ISR
//   vector_level                out  3  level for the vector byte
//   vector_valid                out  1  vector_level is valid
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | resolving requests, INT follows eligibility
// ACK1  | first INTA taken, winner latched, waiting for second INTA
// ACK2  | one cycle, vector presented, optional auto-EOI already applied
// -----------------------------------------------------------------------------
module priority_resolver_in_service #(
  parameter int NUM_LEVELS  = 8,
  parameter int LEVEL_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_LEVELS-1:0]  interrupt_request_register,
  input  logic [NUM_LEVELS-1:0]  interrupt_mask,
  input  logic                   special_mask_mode,
  input  logic [LEVEL_WIDTH-1:0] lowest_priority_level,
  input  logic [NUM_LEVELS-1:0]  end_of_interrupt,
  input  logic                   auto_eoi_config,
  input  logic                   interrupt_acknowledge,
  output logic                   interrupt_out,
  output logic                   freeze,
  output logic [NUM_LEVELS-1:0]  clear_interrupt_request,
  output logic [NUM_LEVELS-1:0]  in_service_register,
  output logic [LEVEL_WIDTH-1:0] vector_level,
  output logic                   vector_valid
);

  import pic_pkg::*;

  pic_state_e             state_q, state_d;
  logic [NUM_LEVELS-1:0]  isr_q, isr_d;
  logic [NUM_LEVELS-1:0]  clear_q, clear_d;
  logic [LEVEL_WIDTH-1:0] winner_q, winner_d;
  logic                   spurious_q, spurious_d;
  logic                   int_q, int_d;

  logic [NUM_LEVELS-1:0]  requests;
  logic [NUM_LEVELS-1:0]  isr_considered;
  logic                   req_found;
  logic [LEVEL_WIDTH-1:0] req_level;
  logic                   isr_found;
  logic [LEVEL_WIDTH-1:0] isr_level;
  logic                   eligible;

  assign requests = interrupt_request_register & ~interrupt_mask;

`ifdef SPECIAL_MASK_MODE_EN
  assign isr_considered = special_mask_mode ? (isr_q & ~interrupt_mask) : isr_q;
`else
  logic unused_special_mask_mode;
  assign unused_special_mask_mode = special_mask_mode;
  assign isr_considered = isr_q;
`endif

  priority_encoder_rotating u_req_encoder (
    .vector_in             (requests),
    .lowest_priority_level (lowest_priority_level),
    .found                 (req_found),
    .index                 (req_level)
  );

  priority_encoder_rotating u_isr_encoder (
    .vector_in             (isr_considered),
    .lowest_priority_level (lowest_priority_level),
    .found                 (isr_found),
    .index                 (isr_level)
  );

  // Strictly higher priority than the best in-service level; an equal level
  // (same bit re-requested while in service) stays blocked.
  assign eligible = req_found &&
                    (!isr_found ||
                     (level_rank(req_level, lowest_priority_level) <
                      level_rank(isr_level, lowest_priority_level)));

  always_comb begin
    state_d    = state_q;
    isr_d      = isr_q & ~end_of_interrupt;
    clear_d    = '0;
    winner_d   = winner_q;
    spurious_d = spurious_q;
    int_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (interrupt_acknowledge) begin
          state_d = ACK1;
          // Winner is captured on the first acknowledge so later mask or
          // rotation changes cannot move it. ISR set overrides a same-cycle EOI.
          if (eligible) begin
            winner_d           = req_level;
            spurious_d         = 1'b0;
            isr_d[req_level]   = 1'b1;
            clear_d[req_level] = 1'b1;
          end else begin
            winner_d   = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end else begin
          int_d = eligible;
        end
      end

      ACK1: begin
        if (interrupt_acknowledge) begin
          state_d = ACK2;
          // Clearing on entry to ACK2 makes the ISR read back as cleared
          // during the vector cycle. A spurious cycle owns no ISR bit.
          if (auto_eoi_config && !spurious_q) begin
            isr_d[winner_q] = 1'b0;
          end
        end
      end

      ACK2: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      isr_q      <= '0;
      clear_q    <= '0;
      winner_q   <= '0;
      spurious_q <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      isr_q      <= isr_d;
      clear_q    <= clear_d;
      winner_q   <= winner_d;
      spurious_q <= spurious_d;
      int_q      <= int_d;
    end
  end

  assign interrupt_out           = int_q;
  assign freeze                  = (state_q != IDLE);
  assign clear_interrupt_request = clear_q;
  assign in_service_register     = isr_q;
  assign vector_valid            = (state_q == ACK2);
  assign vector_level            = (state_q == ACK2) ? winner_q : '0;

endmodule

// File: tb/tb_priority_resolver_in_service.sv
module tb_priority_resolver_in_service;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt_mask;
  logic       special_mask_mode;
  logic [2:0] lowest_priority_level;
  logic [7:0] end_of_interrupt;
  logic       auto_eoi_config;
  logic       interrupt_acknowledge;
  logic       interrupt_out;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] in_service_register;
  logic [2:0] vector_level;
  logic       vector_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int         exp_level_q[$];
  logic [7:0] exp_isr_q[$];
  logic [7:0] m_isr;
  bit         smm_en;

  always #5 clock = ~clock;

  priority_resolver_in_service dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .interrupt_request_register (interrupt_request_register),
    .interrupt_mask             (interrupt_mask),
    .special_mask_mode          (special_mask_mode),
    .lowest_priority_level      (lowest_priority_level),
    .end_of_interrupt           (end_of_interrupt),
    .auto_eoi_config            (auto_eoi_config),
    .interrupt_acknowledge      (interrupt_acknowledge),
    .interrupt_out              (interrupt_out),
    .freeze                     (freeze),
    .clear_interrupt_request    (clear_interrupt_request),
    .in_service_register        (in_service_register),
    .vector_level               (vector_level),
    .vector_valid               (vector_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: rank arithmetic straight from the priority rules.
  function automatic int rank_of(input int lvl, input int rot);
    return (((lvl - rot - 1) % 8) + 8) % 8;
  endfunction

  function automatic int model_winner(input logic [7:0] irr_v, input logic [7:0] mask_v,
                                      input logic [7:0] isr_v, input int rot, input bit smm_v);
    logic [7:0] req;
    logic [7:0] blk;
    int isr_min;
    int best;
    int best_rank;
    req = irr_v & ~mask_v;
    blk = (smm_en && smm_v) ? (isr_v & ~mask_v) : isr_v;
    isr_min = 8;
    for (int i = 0; i < 8; i++)
      if (blk[i] && rank_of(i, rot) < isr_min) isr_min = rank_of(i, rot);
    best = -1;
    best_rank = 8;
    for (int i = 0; i < 8; i++)
      if (req[i] && rank_of(i, rot) < isr_min && rank_of(i, rot) < best_rank) begin
        best = i;
        best_rank = rank_of(i, rot);
      end
    return best;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [7:0] irr_v, input logic [7:0] mask_v,
                         input logic [2:0] rot, input logic smm_v);
    interrupt_request_register = irr_v;
    interrupt_mask             = mask_v;
    lowest_priority_level      = rot;
    special_mask_mode          = smm_v;
    tick();
  endtask

  task automatic apply_eoi(input logic [7:0] eoi);
    end_of_interrupt = eoi;
    tick();
    end_of_interrupt = 8'h00;
    m_isr = m_isr & ~eoi;
    chk("isr_after_eoi", in_service_register, m_isr);
  endtask

  // Two acknowledges; expected vector and ISR go to the scoreboard queues.
  task automatic ack_pair(input bit aeoi, input logic [7:0] eoi_at_ack, input bit perturb);
    int w;
    logic [7:0] exp_clear;
    w = model_winner(interrupt_request_register, interrupt_mask, m_isr,
                     int'(lowest_priority_level), special_mask_mode);
    auto_eoi_config       = aeoi;
    end_of_interrupt      = eoi_at_ack;
    interrupt_acknowledge = 1'b1;
    tick();
    interrupt_acknowledge = 1'b0;
    end_of_interrupt      = 8'h00;
    m_isr = m_isr & ~eoi_at_ack;
    exp_clear = 8'h00;
    if (w >= 0) begin
      m_isr[w]  = 1'b1;
      exp_clear = 8'h01 << w;
    end
    chk("ack1_freeze", freeze, 1);
    chk("ack1_int_low", interrupt_out, 0);
    chk("ack1_clear_pulse", clear_interrupt_request, exp_clear);
    chk("ack1_isr", in_service_register, m_isr);
    if (perturb) begin
      interrupt_request_register = 8'($urandom);
      interrupt_mask             = 8'($urandom);
      lowest_priority_level      = 3'($urandom);
    end
    tick();
    chk("clear_one_cycle", clear_interrupt_request, 8'h00);
    if (aeoi && w >= 0) m_isr[w] = 1'b0;
    exp_level_q.push_back((w >= 0) ? w : 7);
    exp_isr_q.push_back(m_isr);
    interrupt_acknowledge = 1'b1;
    tick();
    interrupt_acknowledge = 1'b0;
    tick();
    chk("freeze_released", freeze, 0);
    chk("vector_valid_low", vector_valid, 0);
    chk("scoreboard_drained", exp_level_q.size(), 0);
  endtask

  // Monitor: pops one expectation per presented vector.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && vector_valid === 1'b1) begin
      if (exp_level_q.size() == 0) begin
        chk("unexpected_vector", vector_valid, 0);
      end else begin
        chk("vector_level", vector_level, exp_level_q.pop_front());
        chk("isr_in_ack2", in_service_register, exp_isr_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SPECIAL_MASK_MODE_EN
    smm_en = 1'b1;
`else
    smm_en = 1'b0;
`endif
    m_isr                      = 8'h00;
    reset_n                    = 1'b0;
    interrupt_request_register = 8'h00;
    interrupt_mask             = 8'h00;
    special_mask_mode          = 1'b0;
    lowest_priority_level      = 3'd7;
    end_of_interrupt           = 8'h00;
    auto_eoi_config            = 1'b0;
    interrupt_acknowledge      = 1'b0;
    tick();
    tick();
    chk("rst_int", interrupt_out, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_clear", clear_interrupt_request, 8'h00);
    chk("rst_isr", in_service_register, 8'h00);
    chk("rst_vector_valid", vector_valid, 0);
    chk("rst_vector_level", vector_level, 3'd0);
    reset_n = 1'b1;

    // 1: level 2 beats level 5 with rot=7
    set_req(8'h24, 8'h00, 3'd7, 1'b0);
    chk("t1_int", interrupt_out, 1);
    ack_pair(1'b0, 8'h00, 1'b0);
    chk("t1_isr", in_service_register, 8'h04);
    apply_eoi(8'h04);

    // 2: ISR level 0 blocks level 1 at rot=7 but not at rot=0
    set_req(8'h01, 8'h00, 3'd7, 1'b0);
    ack_pair(1'b0, 8'h00, 1'b0);
    chk("t2_isr_setup", in_service_register, 8'h01);
    set_req(8'h02, 8'h00, 3'd7, 1'b0);
    tick();
    chk("t2_int_blocked", interrupt_out, 0);
    set_req(8'h02, 8'h00, 3'd0, 1'b0);
    tick();
    chk("t2_int_rotated", interrupt_out, 1);
    set_req(8'h00, 8'h00, 3'd7, 1'b0);
    apply_eoi(8'h01);

    // 3: request disappears before acknowledge -> spurious
    set_req(8'h08, 8'h00, 3'd7, 1'b0);
    chk("t3_int_high", interrupt_out, 1);
    set_req(8'h00, 8'h00, 3'd7, 1'b0);
    chk("t3_int_fell", interrupt_out, 0);
    ack_pair(1'b0, 8'h00, 1'b0);
    chk("t3_isr_unchanged", in_service_register, 8'h00);

    // 4: auto-EOI clears ISR in the vector cycle
    set_req(8'h80, 8'h00, 3'd7, 1'b0);
    ack_pair(1'b1, 8'h00, 1'b0);
    chk("t4_isr_cleared", in_service_register, 8'h00);
    auto_eoi_config = 1'b0;

    // 5: special mask mode unblocks a lower level behind a masked ISR bit
    set_req(8'h01, 8'h00, 3'd7, 1'b0);
    ack_pair(1'b0, 8'h00, 1'b0);
    set_req(8'h10, 8'h01, 3'd7, 1'b1);
    tick();
    chk("t5_int_smm", interrupt_out, smm_en ? 1 : 0);
    set_req(8'h00, 8'h00, 3'd7, 1'b0);
    apply_eoi(8'h01);

    // 6: reset during ACK1
    set_req(8'h02, 8'h00, 3'd7, 1'b0);
    interrupt_acknowledge = 1'b1;
    tick();
    interrupt_acknowledge = 1'b0;
    chk("t6_in_ack1", freeze, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_isr = 8'h00;
    chk("t6_freeze", freeze, 0);
    chk("t6_isr", in_service_register, 8'h00);
    chk("t6_vector_valid", vector_valid, 0);
    chk("t6_clear", clear_interrupt_request, 8'h00);
    // Back in IDLE: a fresh sequence behaves normally.
    set_req(8'h02, 8'h00, 3'd7, 1'b0);
    ack_pair(1'b0, 8'h00, 1'b0);
    apply_eoi(8'hFF);

    // Randomized sequences against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] irr_r;
      logic [7:0] mask_r;
      logic [2:0] rot_r;
      logic       smm_r;
      int         w;
      if ($urandom_range(0, 2) == 0) apply_eoi(8'($urandom));
      irr_r  = 8'($urandom) & 8'($urandom);
      mask_r = 8'($urandom) & 8'($urandom);
      rot_r  = 3'($urandom);
      smm_r  = 1'($urandom);
      set_req(irr_r, mask_r, rot_r, smm_r);
      tick();
      w = model_winner(irr_r, mask_r, m_isr, int'(rot_r), smm_r);
      chk("rand_int", interrupt_out, (w >= 0) ? 1 : 0);
      ack_pair(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
